// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, state type and sizing helper for arb_mux
package mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    // Channel index width; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  NUM_IN = 4,
    parameter int  MODE   = ARB_RR,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  winner
);

    // Search upward from the base, wrapping explicitly so NUM_IN need not be a power of two.
    always_comb begin
        int               base;
        int               idx;
        logic             found;
        logic [SEL_W-1:0] w_idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        base   = (MODE == ARB_FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < NUM_IN; k++) begin
            idx = base + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            w_idx = SEL_W'(idx);
            if (!found && req[w_idx]) begin
                found        = 1'b1;
                grant[w_idx] = 1'b1;
                winner       = w_idx;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - registered N-to-1 mux with internal arbitration and valid/ready handshake
module arb_mux
    import mux_pkg::*;
#(
    parameter int  WIDTH  = 16,
    parameter int  NUM_IN = 4,
    parameter int  MODE   = ARB_RR,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  w_winner;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic [NUM_IN-1:0] w_grant;
    logic [WIDTH-1:0]  w_win_data;
    logic              w_load;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .MODE   (MODE)
    ) u_arb (
        .req    (in_valid),
        .ptr    (r_ptr),
        .grant  (w_grant),
        .winner (w_winner)
    );

    // A load is allowed when the output slot is free or being drained this edge.
    assign w_load    = !reset && (|in_valid) && ((r_state == S_EMPTY) || out_ready);
    assign in_ready  = w_load ? w_grant : '0;
    assign w_ptr_nxt = (int'(w_winner) == NUM_IN - 1) ? '0 : w_winner + SEL_W'(1);

    always_comb begin
        w_win_data = in_data[int'(w_winner)*WIDTH +: WIDTH];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_load) w_state_nxt = S_FULL;
            S_FULL:  if (out_ready && !w_load) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_data <= w_win_data;
                r_sel  <= w_winner;
                if (MODE == ARB_RR) r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
